// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier with an IDLE/RUN/DONE controller.
// One partial product per clock; the lowest TRUNC product bits are forced to
// zero as an optional approximation.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Wide enough to hold WIDTH itself, so the counter never wraps.
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);
  // Shifting all ones left by TRUNC clears exactly the truncated columns;
  // TRUNC == 2*WIDTH yields an all-zero mask.
  localparam logic [2*WIDTH-1:0] Mask = {(2*WIDTH){1'b1}} << TRUNC;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic and one shift-add iteration per RUN cycle.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    addend    = '0;
    sum       = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Carry-out lands in the MSB; the consumed LSB falls off the bottom.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d   = StDone;
          product_d = acc_d & Mask;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule
